// File: rtl/vga_pkg.sv
// Shared VGA timing constants and timing descriptors for video blocks.
package vga_pkg;

  localparam int unsigned VGA_H_ACTIVE = 640;
  localparam int unsigned VGA_H_FP     = 16;
  localparam int unsigned VGA_H_SYNC   = 96;
  localparam int unsigned VGA_H_BP     = 48;
  localparam int unsigned VGA_V_ACTIVE = 480;
  localparam int unsigned VGA_V_FP     = 10;
  localparam int unsigned VGA_V_SYNC   = 2;
  localparam int unsigned VGA_V_BP     = 33;
  localparam bit          VGA_H_POL    = 1'b0;
  localparam bit          VGA_V_POL    = 1'b0;
  localparam int unsigned VGA_CW       = 10;

  typedef struct packed {
    logic [15:0] active;
    logic [15:0] fp;
    logic [15:0] sync;
    logic [15:0] bp;
  } vga_axis_t;

  typedef struct packed {
    vga_axis_t h;
    vga_axis_t v;
    logic      h_pol;
    logic      v_pol;
  } vga_timing_t;

  // Total length of one axis: active + front porch + sync + back porch.
  function automatic int unsigned axis_total(input int unsigned active, input int unsigned fp,
                                             input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Video timing bundle from a timing generator to its sink.
interface vga_timing_gen_if #(
  parameter int unsigned CW = 10
);
  logic          h_sync;
  logic          v_sync;
  logic          de;
  logic [CW-1:0] x;
  logic [CW-1:0] y;
  logic          sof;
  logic          eol;
  logic          vblank;
  logic [7:0]    frame_cnt;

  modport master (output h_sync, v_sync, de, x, y, sof, eol, vblank, frame_cnt);
  modport slave  (input  h_sync, v_sync, de, x, y, sof, eol, vblank, frame_cnt);
endinterface

// File: rtl/vga_axis_counter.sv
// One timing axis: position counter with wrap and active/sync region decode.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int unsigned ACTIVE = VGA_H_ACTIVE,
  parameter int unsigned FP     = VGA_H_FP,
  parameter int unsigned SYNC   = VGA_H_SYNC,
  parameter int unsigned BP     = VGA_H_BP,
  parameter int unsigned CW     = VGA_CW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          step,
  input  logic          clear,
  output logic [CW-1:0] cnt,
  output logic          last_c,
  output logic          active_c,
  output logic          sync_c
);

  localparam int unsigned TOTAL      = axis_total(ACTIVE, FP, SYNC, BP);
  localparam int unsigned SYNC_START = ACTIVE + FP;
  localparam int unsigned SYNC_END   = SYNC_START + SYNC;
  localparam int unsigned XW         = CW + 1;

  if (64'(TOTAL) > (64'(1) << CW)) begin : g_range_check
    $error("vga_axis_counter: total %0d does not fit in %0d bits", TOTAL, CW);
  end

  // Region bounds may equal 2**CW, so decode one bit wider than the counter.
  logic [XW-1:0] cnt_x;
  assign cnt_x    = {1'b0, cnt};
  assign last_c   = (cnt == CW'(TOTAL - 1));
  assign active_c = (cnt_x < XW'(ACTIVE));
  assign sync_c   = (cnt_x >= XW'(SYNC_START)) && (cnt_x < XW'(SYNC_END));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (step) begin
      cnt <= last_c ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA sync/position generator: two axis counters feeding a registered output stage.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
  parameter int unsigned H_FP     = VGA_H_FP,
  parameter int unsigned H_SYNC   = VGA_H_SYNC,
  parameter int unsigned H_BP     = VGA_H_BP,
  parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
  parameter int unsigned V_FP     = VGA_V_FP,
  parameter int unsigned V_SYNC   = VGA_V_SYNC,
  parameter int unsigned V_BP     = VGA_V_BP,
  parameter bit          H_POL    = VGA_H_POL,
  parameter bit          V_POL    = VGA_V_POL,
  parameter int unsigned CW       = VGA_CW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pix_ce,
  input  logic             restart,
  vga_timing_gen_if.master vid
);

  logic [CW-1:0] hcnt;
  logic [CW-1:0] vcnt;
  logic          h_last_c, h_act_c, h_sync_c;
  logic          v_last_c, v_act_c, v_sync_c;
  logic          clear_c;
  logic          v_step_c;

  assign clear_c  = pix_ce & restart;
  assign v_step_c = pix_ce & h_last_c;

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .CW(CW)
  ) u_h (
    .clk(clk), .rst_n(rst_n), .step(pix_ce), .clear(clear_c),
    .cnt(hcnt), .last_c(h_last_c), .active_c(h_act_c), .sync_c(h_sync_c)
  );

  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .CW(CW)
  ) u_v (
    .clk(clk), .rst_n(rst_n), .step(v_step_c), .clear(clear_c),
    .cnt(vcnt), .last_c(v_last_c), .active_c(v_act_c), .sync_c(v_sync_c)
  );

  // Outputs show the position the counters held at the enabling edge; pulses last one clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vid.x         <= '0;
      vid.y         <= '0;
      vid.de        <= 1'b0;
      vid.h_sync    <= ~H_POL;
      vid.v_sync    <= ~V_POL;
      vid.vblank    <= 1'b0;
      vid.sof       <= 1'b0;
      vid.eol       <= 1'b0;
      vid.frame_cnt <= '0;
    end else begin
      vid.sof <= 1'b0;
      vid.eol <= 1'b0;
      if (pix_ce) begin
        vid.x      <= hcnt;
        vid.y      <= vcnt;
        vid.de     <= h_act_c & v_act_c;
        vid.h_sync <= h_sync_c ? H_POL : ~H_POL;
        vid.v_sync <= v_sync_c ? V_POL : ~V_POL;
        vid.vblank <= ~v_act_c;
        vid.sof    <= (hcnt == '0) && (vcnt == '0);
        vid.eol    <= h_last_c;
        // Only a natural end-of-frame wrap counts; restart discards the frame.
        if (h_last_c && v_last_c && !restart) begin
          vid.frame_cnt <= vid.frame_cnt + 8'd1;
        end
      end
    end
  end

endmodule
